axi_lite_slave_mem: RTL and testbench
=====================================

Name: axi_lite_slave_mem

Overview:
- Single-beat AXI-lite slave memory that terminates the slave side of axi_lite_inf. It is the downstream consumer of every master transaction.
- Holds a word-addressed storage array. Write address and write data are accepted independently and buffered, then committed together. Every write gets a B response and every read an R response, with IDs echoed back.
- Out-of-range addresses return an error response and never corrupt storage.

Parameters:
- DATA_SIZE, 32, data width in bits (wdata/rdata).
- ADDR_SIZE, 32, byte address width.
- ID_SIZE, 32, transaction ID width.
- DEPTH, 64, number of DATA_SIZE words; a power of two, at least 2.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- awvalid, awready  in/out  1  write address handshake.
- awaddr  input  ADDR_SIZE  write byte address.
- awid  input  ID_SIZE  write ID.
- awsize, awlen, awburst  input  1  accepted and ignored (single beat only).
- wvalid, wready  in/out  1  write data handshake.
- wdata  input  DATA_SIZE  write data.
- wlast  input  1  ignored; every beat is treated as last.
- bvalid  output  1  write response valid.
- bready  input  1  write response accept.
- bresp  output  1  0=OKAY, 1=SLVERR.
- bid  output  ID_SIZE  echoed awid.
- arvalid, arready  in/out  1  read address handshake.
- araddr  input  ADDR_SIZE  read byte address.
- arid  input  ID_SIZE  read ID.
- arsize  input  1  ignored.
- rvalid  output  1  read data valid.
- rready  input  1  read data accept.
- rdata  output  DATA_SIZE  read data.
- rlast  output  1  driven 1 whenever rvalid=1, else 0.
- rid  output  ID_SIZE  echoed arid.
- rresp  output  1  0=OKAY, 1=SLVERR.

Behaviour:
Reset:
- reset_n low clears all outputs and internal flags asynchronously: valids, resps, ids, rdata and rlast go to 0.
- Storage contents are also cleared to 0.
- Reset mid-transaction drops any buffered AW/W/B/R; no response is issued afterwards.

Address decode:
- Word index = addr[LSB +: log2(DEPTH)], where LSB = log2(DATA_SIZE/8).
- In range iff addr < DEPTH*(DATA_SIZE/8). Low byte-offset bits are ignored, i.e. the address is treated as aligned.

Write channel (one holding register each for AW and W):
- awready = !aw_held; wready = !w_held. Registered, so ready is low in the cycle after capture.
- Commit fires in the cycle where aw_held && w_held && !bvalid_pending.
  - If in range: mem[idx] <= wdata and bresp <= 0.
  - If out of range: no write and bresp <= 1.
  - In both cases bid <= awid, bvalid <= 1, and both held flags clear.
- bvalid holds with stable bid/bresp until bvalid && bready; it clears on that edge.
- A new commit can happen in the cycle bvalid clears, at the earliest.
- AW before W, W before AW, and both in the same cycle are all legal.
- Latency when both handshakes land in cycle N: bvalid asserts in cycle N+2 (capture, then commit).

Read channel:
- arready = !rvalid.
- On arvalid && arready:
  - rdata <= in range ? mem[idx] : 0
  - rresp <= !in_range
  - rid <= arid
  - rvalid <= 1 (rvalid is high in cycle N+1)
- rvalid, rdata, rid and rresp hold stable until rvalid && rready. No new AR is accepted while rvalid=1.
- Max read throughput is one transaction every 2 cycles.

Simultaneous events:
- Write commit and AR handshake to the same index in the same cycle: the read returns the old data (read-before-write).
- Read and write paths are otherwise fully independent.
- bready and rready held low stall only their own channel.

Decomposition:
- Package axi_lite_pkg:
  - RESP_OKAY=1'b0 and RESP_SLVERR=1'b1.
  - Function clog2-based index width helper.
  - Typedef aw_hold_t {addr, id} for the AW holding register.
- One sub-module, axi_lite_regmem: DEPTH x DATA_SIZE array with one synchronous write port and one synchronous read port, with old-data-on-collision semantics and async clear.
- Handshake/FSM logic stays in axi_lite_slave_mem.

Test Plan:
1. AW and W in the same cycle, addr 0x10, data 0xDEADBEEF, awid 5, bready=1 -> bvalid two cycles later with bresp=0, bid=5. Then AR 0x10, arid 9 -> rvalid next cycle with rdata=0xDEADBEEF, rid=9, rresp=0, rlast=1.
2. W three cycles before AW (addr 0x4, data 0x1234) -> awready stays 1 and wready drops after W capture. Single commit, one bvalid; a later read of 0x4 returns 0x1234.
3. Out-of-range write and read at addr 0x100 (DEPTH=64, 32-bit) -> bresp=1, rresp=1, rdata=0. A read of index 0 afterwards shows it unchanged.
4. bready held low for 5 cycles after bvalid, with a second AW/W offered -> second write is captured but not committed. bid/bresp stay stable. The second bvalid appears only after the first handshake.
5. Write to 0x8 (0xA5A5A5A5) commits in the same cycle as an AR to 0x8 while mem[2]=0x0 -> read returns 0x0; a subsequent read returns 0xA5A5A5A5.
6. reset_n pulsed low while aw_held=1 and rvalid=1 -> all outputs are 0 immediately. After release, no bvalid appears and a read of any address returns 0.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared constants, types and helpers for the AXI-lite slave memory.
package axi_lite_pkg;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  // Widest address/ID the AW holding register can carry; narrower
  // instances zero-extend into it and slice back out.
  localparam int AXI_MAX_ADDR_W = 64;
  localparam int AXI_MAX_ID_W   = 64;

  // Number of index bits needed to address depth words (never below 1).
  function automatic int idxWidth(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic [AXI_MAX_ADDR_W-1:0] addr;
    logic [AXI_MAX_ID_W-1:0]   id;
  } aw_hold_t;

endpackage

// File: rtl/axi_lite_regmem.sv
// DEPTH x DATA_SIZE register array: one synchronous write port, one
// synchronous read port returning old data on collision, async clear.
module axi_lite_regmem
  import axi_lite_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 64,
  localparam int IDX_W    = idxWidth(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_wrEn,
  input  logic [IDX_W-1:0]     i_wrIdx,
  input  logic [DATA_SIZE-1:0] i_wrData,
  input  logic                 i_rdEn,
  input  logic                 i_rdZero,
  input  logic [IDX_W-1:0]     i_rdIdx,
  output logic [DATA_SIZE-1:0] o_rdData
);

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [DATA_SIZE-1:0] r_rdData;

  // Storage: cleared on reset, written one word per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wrEn) begin
      r_mem[i_wrIdx] <= i_wrData;
    end
  end

  // Read register: samples pre-write contents, or zero for a rejected address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdData <= '0;
    end else if (i_rdEn) begin
      r_rdData <= i_rdZero ? '0 : r_mem[i_rdIdx];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/axi_lite_slave_mem.sv
// Single-beat AXI-lite slave in front of a word-addressed register memory.
module axi_lite_slave_mem
  import axi_lite_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int ID_SIZE   = 32,
  parameter int DEPTH     = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [ADDR_SIZE-1:0] awaddr,
  input  logic [ID_SIZE-1:0]   awid,
  input  logic                 awsize,
  input  logic                 awlen,
  input  logic                 awburst,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 wlast,
  output logic                 bvalid,
  input  logic                 bready,
  output logic                 bresp,
  output logic [ID_SIZE-1:0]   bid,
  input  logic                 arvalid,
  output logic                 arready,
  input  logic [ADDR_SIZE-1:0] araddr,
  input  logic [ID_SIZE-1:0]   arid,
  input  logic                 arsize,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rlast,
  output logic [ID_SIZE-1:0]   rid,
  output logic                 rresp
);

  localparam int BYTES = DATA_SIZE / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = idxWidth(DEPTH);
  localparam int TOP   = LSB + IDX_W;

  aw_hold_t             r_awHold;
  logic                 r_awHeld;
  logic                 r_wHeld;
  logic [DATA_SIZE-1:0] r_wData;
  logic                 r_bvalid;
  logic                 r_bresp;
  logic [ID_SIZE-1:0]   r_bid;
  logic                 r_rvalid;
  logic                 r_rresp;
  logic [ID_SIZE-1:0]   r_rid;

  logic [ADDR_SIZE-1:0] w_awAddr;
  logic                 w_awInRange;
  logic                 w_arInRange;
  logic                 w_commit;
  logic                 w_arFire;
  logic                 w_unusedBits;

  // Power-of-two depth: an address is in range exactly when no bit above the index is set.
  assign w_awAddr    = r_awHold.addr[ADDR_SIZE-1:0];
  assign w_awInRange = (w_awAddr >> TOP) == '0;
  assign w_arInRange = (araddr >> TOP) == '0;
  assign w_commit    = r_awHeld && r_wHeld && !r_bvalid;
  assign w_arFire    = arvalid && !r_rvalid;

  // Single-beat attributes carry no information for this slave.
  assign w_unusedBits = ^{awsize, awlen, awburst, wlast, arsize, r_awHold};

  // AW and W holding registers: each fills independently, both empty on commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_awHeld <= 1'b0;
      r_awHold <= '0;
      r_wHeld  <= 1'b0;
      r_wData  <= '0;
    end else begin
      if (w_commit) begin
        r_awHeld <= 1'b0;
        r_wHeld  <= 1'b0;
      end
      if (awvalid && !r_awHeld) begin
        r_awHeld      <= 1'b1;
        r_awHold.addr <= AXI_MAX_ADDR_W'(awaddr);
        r_awHold.id   <= AXI_MAX_ID_W'(awid);
      end
      if (wvalid && !r_wHeld) begin
        r_wHeld <= 1'b1;
        r_wData <= wdata;
      end
    end
  end

  // Write response: raised by a commit, held stable until the master takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
      r_bid    <= '0;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_awInRange ? RESP_OKAY : RESP_SLVERR;
      r_bid    <= r_awHold.id[ID_SIZE-1:0];
    end else if (r_bvalid && bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read response: one outstanding read, accepted only while no response is pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rid    <= '0;
    end else if (w_arFire) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_arInRange ? RESP_OKAY : RESP_SLVERR;
      r_rid    <= arid;
    end else if (r_rvalid && rready) begin
      r_rvalid <= 1'b0;
    end
  end

  axi_lite_regmem #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH)
  ) u_regmem (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_wrEn   (w_commit && w_awInRange),
    .i_wrIdx  (w_awAddr[LSB +: IDX_W]),
    .i_wrData (r_wData),
    .i_rdEn   (w_arFire),
    .i_rdZero (!w_arInRange),
    .i_rdIdx  (araddr[LSB +: IDX_W]),
    .o_rdData (rdata)
  );

  assign awready = !r_awHeld;
  assign wready  = !r_wHeld;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign bid     = r_bid;
  assign arready = !r_rvalid;
  assign rvalid  = r_rvalid;
  assign rlast   = r_rvalid;
  assign rid     = r_rid;
  assign rresp   = r_rresp;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Self-checking bench for axi_lite_slave_mem against a word-array reference model.
module tb_axi_lite_slave_mem;

  localparam int DATA_SIZE = 32;
  localparam int ADDR_SIZE = 32;
  localparam int ID_SIZE   = 32;
  localparam int DEPTH     = 64;
  localparam int MEM_BYTES = DEPTH * (DATA_SIZE / 8);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic awvalid, awready, awsize, awlen, awburst;
  logic [31:0] awaddr, awid;
  logic wvalid, wready, wlast;
  logic [31:0] wdata;
  logic bvalid, bready, bresp;
  logic [31:0] bid;
  logic arvalid, arready, arsize;
  logic [31:0] araddr, arid;
  logic rvalid, rready, rlast, rresp;
  logic [31:0] rdata, rid;

  int checkCount = 0;
  int passCount = 0;
  logic [31:0] model [DEPTH];

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  axi_lite_slave_mem #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE),
    .ID_SIZE   (ID_SIZE),
    .DEPTH     (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .awvalid (awvalid),
    .awready (awready),
    .awaddr  (awaddr),
    .awid    (awid),
    .awsize  (awsize),
    .awlen   (awlen),
    .awburst (awburst),
    .wvalid  (wvalid),
    .wready  (wready),
    .wdata   (wdata),
    .wlast   (wlast),
    .bvalid  (bvalid),
    .bready  (bready),
    .bresp   (bresp),
    .bid     (bid),
    .arvalid (arvalid),
    .arready (arready),
    .araddr  (araddr),
    .arid    (arid),
    .arsize  (arsize),
    .rvalid  (rvalid),
    .rready  (rready),
    .rdata   (rdata),
    .rlast   (rlast),
    .rid     (rid),
    .rresp   (rresp)
  );

  // Reference model: byte address -> expected read word.
  function automatic logic [31:0] expRead(input logic [31:0] a);
    if (a < MEM_BYTES) return model[int'(a / 4)];
    return 32'h0;
  endfunction

  // Offer AW and W; mode 0 together, 1 AW two cycles early, 2 W two cycles early.
  task automatic sendWrite(input logic [31:0] a, input logic [31:0] d, input logic [31:0] id, input int mode);
    logic awDone, wDone, awGo, wGo;
    int cyc;
    awaddr = a; awid = id; wdata = d;
    awDone = 1'b0; wDone = 1'b0; cyc = 0;
    awvalid = (mode != 2);
    wvalid = (mode != 1);
    while (!(awDone && wDone) && cyc < 50) begin
      awGo = awvalid && awready;
      wGo = wvalid && wready;
      @(negedge clk);
      cyc++;
      if (awGo) begin awvalid = 1'b0; awDone = 1'b1; end
      if (wGo) begin wvalid = 1'b0; wDone = 1'b1; end
      if (cyc == 2) begin
        if (!awDone) awvalid = 1'b1;
        if (!wDone) wvalid = 1'b1;
      end
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
  endtask

  // Wait (bounded) for a write response, stall bready, then accept it.
  task automatic collectB(input int stall, output logic got, output logic [31:0] idV, output logic respV);
    got = 1'b0; idV = '0; respV = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bvalid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (got) begin
      idV = bid; respV = bresp;
      repeat (stall) @(negedge clk);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
    end
  endtask

  // Issue one read (bounded waits), stall rready, then accept the response.
  task automatic doRead(input logic [31:0] a, input logic [31:0] id, input int stall, output logic got, output logic [31:0] d, output logic resp, output logic [31:0] idV, output logic last);
    got = 1'b0; d = '0; resp = 1'b0; idV = '0; last = 1'b0;
    arvalid = 1'b1; araddr = a; arid = id;
    for (int k = 0; k < 50; k++) begin
      if (arready) break;
      @(negedge clk);
    end
    @(negedge clk);
    arvalid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (rvalid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (got) begin
      d = rdata; resp = rresp; idV = rid; last = rlast;
      repeat (stall) @(negedge clk);
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  // Outputs while reset is held low.
  task automatic test_reset();
    checkCount++; if (bvalid !== 1'b0) $display("[TB] FAIL reset_bvalid got %0h exp 0", bvalid); else passCount++;
    checkCount++; if (rvalid !== 1'b0) $display("[TB] FAIL reset_rvalid got %0h exp 0", rvalid); else passCount++;
    checkCount++; if (rlast !== 1'b0) $display("[TB] FAIL reset_rlast got %0h exp 0", rlast); else passCount++;
    checkCount++; if ({bid, rid, rdata} !== 96'h0) $display("[TB] FAIL reset_ids_data got %0h exp 0", {bid, rid, rdata}); else passCount++;
    checkCount++; if ({bresp, rresp} !== 2'b00) $display("[TB] FAIL reset_resp got %0h exp 0", {bresp, rresp}); else passCount++;
    checkCount++; if ({awready, wready, arready} !== 3'b111) $display("[TB] FAIL reset_ready got %0h exp 7", {awready, wready, arready}); else passCount++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // AW+W same cycle, response two edges later, then read back.
  task automatic test_basic();
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h10; wdata = 32'hDEADBEEF; awid = 32'd5; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    checkCount++; if (bvalid !== 1'b0) $display("[TB] FAIL basic_bvalid_early got %0h exp 0", bvalid); else passCount++;
    checkCount++; if ({awready, wready} !== 2'b00) $display("[TB] FAIL basic_ready_after_capture got %0h exp 0", {awready, wready}); else passCount++;
    @(negedge clk);
    checkCount++; if (bvalid !== 1'b1) $display("[TB] FAIL basic_bvalid got %0h exp 1", bvalid); else passCount++;
    checkCount++; if (bid !== 32'd5) $display("[TB] FAIL basic_bid got %0h exp 5", bid); else passCount++;
    checkCount++; if (bresp !== 1'b0) $display("[TB] FAIL basic_bresp got %0h exp 0", bresp); else passCount++;
    model[4] = 32'hDEADBEEF;
    @(negedge clk);
    bready = 1'b0;
    checkCount++; if (bvalid !== 1'b0) $display("[TB] FAIL basic_bvalid_clear got %0h exp 0", bvalid); else passCount++;
    arvalid = 1'b1; araddr = 32'h10; arid = 32'd9;
    @(negedge clk);
    arvalid = 1'b0;
    checkCount++; if (rvalid !== 1'b1) $display("[TB] FAIL basic_rvalid got %0h exp 1", rvalid); else passCount++;
    checkCount++; if (rdata !== expRead(32'h10)) $display("[TB] FAIL basic_rdata got %0h exp %0h", rdata, expRead(32'h10)); else passCount++;
    checkCount++; if ({rid, rresp, rlast} !== {32'd9, 1'b0, 1'b1}) $display("[TB] FAIL basic_rid_rresp_rlast got %0h exp %0h", {rid, rresp, rlast}, {32'd9, 1'b0, 1'b1}); else passCount++;
    checkCount++; if (arready !== 1'b0) $display("[TB] FAIL basic_arready_busy got %0h exp 0", arready); else passCount++;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    checkCount++; if ({rvalid, rlast} !== 2'b00) $display("[TB] FAIL basic_rvalid_clear got %0h exp 0", {rvalid, rlast}); else passCount++;
  endtask

  // W arrives three cycles before AW: one commit, one response.
  task automatic test_w_before_aw();
    logic got, resp, last;
    logic [31:0] idV, d;
    int extra;
    wvalid = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    wvalid = 1'b0;
    checkCount++; if ({awready, wready} !== 2'b10) $display("[TB] FAIL wfirst_ready got %0h exp 2", {awready, wready}); else passCount++;
    repeat (2) @(negedge clk);
    checkCount++; if ({awready, wready, bvalid} !== 3'b100) $display("[TB] FAIL wfirst_wait got %0h exp 4", {awready, wready, bvalid}); else passCount++;
    awvalid = 1'b1; awaddr = 32'h4; awid = 32'h22;
    @(negedge clk);
    awvalid = 1'b0;
    collectB(0, got, idV, resp);
    model[1] = 32'h1234;
    checkCount++; if ({got, idV, resp} !== {1'b1, 32'h22, 1'b0}) $display("[TB] FAIL wfirst_b got %0h exp %0h", {got, idV, resp}, {1'b1, 32'h22, 1'b0}); else passCount++;
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      if (bvalid) extra++;
      @(negedge clk);
    end
    checkCount++; if (extra !== 0) $display("[TB] FAIL wfirst_extra_b got %0d exp 0", extra); else passCount++;
    doRead(32'h4, 32'h1, 0, got, d, resp, idV, last);
    checkCount++; if ({got, d} !== {1'b1, expRead(32'h4)}) $display("[TB] FAIL wfirst_read got %0h exp %0h", {got, d}, {1'b1, expRead(32'h4)}); else passCount++;
  endtask

  // Out-of-range write and read must error and leave storage untouched.
  task automatic test_out_of_range();
    logic got, resp, last;
    logic [31:0] idV, d;
    sendWrite(32'h100, 32'hCAFEF00D, 32'd7, 0);
    collectB(1, got, idV, resp);
    checkCount++; if ({got, idV, resp} !== {1'b1, 32'd7, 1'b1}) $display("[TB] FAIL oor_b got %0h exp %0h", {got, idV, resp}, {1'b1, 32'd7, 1'b1}); else passCount++;
    doRead(32'h100, 32'd8, 0, got, d, resp, idV, last);
    checkCount++; if ({got, d, resp, idV} !== {1'b1, 32'h0, 1'b1, 32'd8}) $display("[TB] FAIL oor_read got %0h exp %0h", {got, d, resp, idV}, {1'b1, 32'h0, 1'b1, 32'd8}); else passCount++;
    doRead(32'h0, 32'd3, 0, got, d, resp, idV, last);
    checkCount++; if ({got, d, resp} !== {1'b1, expRead(32'h0), 1'b0}) $display("[TB] FAIL oor_idx0 got %0h exp %0h", {got, d, resp}, {1'b1, expRead(32'h0), 1'b0}); else passCount++;
  endtask

  // bready held low: a second write is captured but not committed.
  task automatic test_b_backpressure();
    logic got, resp, last, stable;
    logic [31:0] idV, d;
    int k;
    sendWrite(32'h20, 32'h11112222, 32'h11, 0);
    for (k = 0; k < 50 && !bvalid; k++) @(negedge clk);
    model[8] = 32'h11112222;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h24; wdata = 32'h33334444; awid = 32'h12;
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      if (!(bvalid === 1'b1 && bid === 32'h11 && bresp === 1'b0)) stable = 1'b0;
    end
    checkCount++; if (stable !== 1'b1) $display("[TB] FAIL bp_stable got %0h exp 1", stable); else passCount++;
    checkCount++; if ({awready, wready} !== 2'b00) $display("[TB] FAIL bp_second_held got %0h exp 0", {awready, wready}); else passCount++;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checkCount++; if (bvalid !== 1'b0) $display("[TB] FAIL bp_gap got %0h exp 0", bvalid); else passCount++;
    @(negedge clk);
    checkCount++; if ({bvalid, bid, bresp} !== {1'b1, 32'h12, 1'b0}) $display("[TB] FAIL bp_second_b got %0h exp %0h", {bvalid, bid, bresp}, {1'b1, 32'h12, 1'b0}); else passCount++;
    model[9] = 32'h33334444;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    doRead(32'h24, 32'h2, 0, got, d, resp, idV, last);
    checkCount++; if ({got, d} !== {1'b1, expRead(32'h24)}) $display("[TB] FAIL bp_read2 got %0h exp %0h", {got, d}, {1'b1, expRead(32'h24)}); else passCount++;
    doRead(32'h20, 32'h3, 2, got, d, resp, idV, last);
    checkCount++; if ({got, d} !== {1'b1, expRead(32'h20)}) $display("[TB] FAIL bp_read1 got %0h exp %0h", {got, d}, {1'b1, expRead(32'h20)}); else passCount++;
  endtask

  // Commit and AR to the same word on the same edge: read sees old data.
  task automatic test_collision();
    logic got, resp, last;
    logic [31:0] idV, d, oldV;
    oldV = expRead(32'h8);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h8; wdata = 32'hA5A5A5A5; awid = 32'd3;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = 32'h8; arid = 32'd4;
    @(negedge clk);
    arvalid = 1'b0;
    model[2] = 32'hA5A5A5A5;
    checkCount++; if ({rvalid, bvalid} !== 2'b11) $display("[TB] FAIL coll_valids got %0h exp 3", {rvalid, bvalid}); else passCount++;
    checkCount++; if (rdata !== oldV) $display("[TB] FAIL coll_old_data got %0h exp %0h", rdata, oldV); else passCount++;
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    doRead(32'h8, 32'd6, 0, got, d, resp, idV, last);
    checkCount++; if ({got, d} !== {1'b1, expRead(32'h8)}) $display("[TB] FAIL coll_new_data got %0h exp %0h", {got, d}, {1'b1, expRead(32'h8)}); else passCount++;
  endtask

  // Random mix of writes and reads, with offsets, out-of-range and stalls.
  task automatic test_random();
    logic got, resp, last, expResp;
    logic [31:0] a, d, id, idV, rd, expD;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 79) * 4) + $urandom_range(0, 3);
      id = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        sendWrite(a, d, id, int'($urandom_range(0, 2)));
        collectB(int'($urandom_range(0, 3)), got, idV, resp);
        expResp = (a >= MEM_BYTES);
        if (!expResp) model[int'(a / 4)] = d;
        checkCount++; if ({got, idV, resp} !== {1'b1, id, expResp}) $display("[TB] FAIL rand_write a=%0h got %0h exp %0h", a, {got, idV, resp}, {1'b1, id, expResp}); else passCount++;
      end else begin
        expD = expRead(a);
        expResp = (a >= MEM_BYTES);
        doRead(a, id, int'($urandom_range(0, 3)), got, rd, resp, idV, last);
        checkCount++; if ({got, rd, resp, idV, last} !== {1'b1, expD, expResp, id, 1'b1}) $display("[TB] FAIL rand_read a=%0h got %0h exp %0h", a, {got, rd, resp, idV, last}, {1'b1, expD, expResp, id, 1'b1}); else passCount++;
      end
    end
  endtask

  // Reset mid-transaction drops everything and clears storage.
  task automatic test_reset_mid();
    logic got, resp, last;
    logic [31:0] idV, d, a;
    int sawB;
    awvalid = 1'b1; awaddr = 32'h30; awid = 32'h44;
    arvalid = 1'b1; araddr = 32'h10; arid = 32'h55;
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    checkCount++; if ({awready, rvalid} !== 2'b01) $display("[TB] FAIL rstmid_pre got %0h exp 1", {awready, rvalid}); else passCount++;
    #2 reset_n = 1'b0;
    #1;
    checkCount++; if ({bvalid, rvalid, rlast, bresp, rresp} !== 5'b0) $display("[TB] FAIL rstmid_flags got %0h exp 0", {bvalid, rvalid, rlast, bresp, rresp}); else passCount++;
    checkCount++; if ({rdata, rid, bid} !== 96'h0) $display("[TB] FAIL rstmid_data got %0h exp 0", {rdata, rid, bid}); else passCount++;
    for (int k = 0; k < DEPTH; k++) model[k] = 32'h0;
    @(negedge clk);
    reset_n = 1'b1;
    wvalid = 1'b1; wdata = 32'h77777777;
    @(negedge clk);
    wvalid = 1'b0;
    sawB = 0;
    for (int k = 0; k < 6; k++) begin
      if (bvalid) sawB++;
      @(negedge clk);
    end
    checkCount++; if (sawB !== 0) $display("[TB] FAIL rstmid_no_b got %0d exp 0", sawB); else passCount++;
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 32'h10 : 32'($urandom_range(0, 63) * 4);
      doRead(a, 32'h9, 0, got, d, resp, idV, last);
      checkCount++; if ({got, d} !== {1'b1, expRead(a)}) $display("[TB] FAIL rstmid_read a=%0h got %0h exp %0h", a, {got, d}, {1'b1, expRead(a)}); else passCount++;
    end
  endtask

  // Test sequence.
  initial begin
    awvalid = 1'b0; awaddr = '0; awid = '0; awsize = 1'b0; awlen = 1'b0; awburst = 1'b0;
    wvalid = 1'b0; wdata = '0; wlast = 1'b1; bready = 1'b0;
    arvalid = 1'b0; araddr = '0; arid = '0; arsize = 1'b0; rready = 1'b0;
    for (int k = 0; k < DEPTH; k++) model[k] = 32'h0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_w_before_aw();
    test_out_of_range();
    test_b_backpressure();
    test_collision();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
